oam_dma_controller: RTL and testbench

//  Sequences OAM DMA and arbitrates the main memory bus between the CPU core and
//  the DMA engine. Sits in interconnect between core and memory decode.
//  CPU write to DMA register copies DMA_LEN bytes from {page,8'h00} to DEST_BASE.

---
 rtl/oam_dma_controller_pkg.sv | 22 ++
 rtl/oam_dma_controller_dma_sequencer.sv | 90 +++++++++
 rtl/oam_dma_controller.sv | 129 ++++++++++++
 tb/tb_oam_dma_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_controller_pkg.sv
// rtl/oam_dma_controller_pkg.sv - shared encodings and constants for the OAM DMA controller
package oam_dma_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } dma_state_t;

    typedef enum logic [1:0] {
        SEL_BUS   = 2'd0,
        SEL_HI    = 2'd1,
        SEL_REG   = 2'd2,
        SEL_CONST = 2'd3
    } rdata_sel_t;

    localparam logic [7:0] HIGH_PAGE   = 8'hFF;
    localparam logic [7:0] RDATA_CONST = 8'hFF;
    localparam logic [7:0] PAGE_RESET  = 8'hFF;

endpackage

// File: rtl/oam_dma_controller_dma_sequencer.sv
// rtl/oam_dma_controller_dma_sequencer.sv - OAM DMA state machine driving the main-bus copy cycles
module oam_dma_controller_dma_sequencer
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] DEST_BASE   = 16'hFE00,
    parameter int          DMA_LEN     = 160,
    parameter int          START_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  page,
    input  logic [7:0]  bus_rdata,
    output logic        active,
    output logic        rd,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  wdata
);

    localparam logic [7:0] LAST_IDX    = 8'(DMA_LEN - 1);
    localparam logic [7:0] DELAY_LAST  = 8'(START_DELAY - 1);
    localparam dma_state_t START_STATE = (START_DELAY == 0) ? ST_RD : ST_DELAY;

    dma_state_t state, state_n;
    logic [7:0] idx, idx_n;
    logic [7:0] cnt, cnt_n;

    assign active = (state != ST_IDLE);

    // State, byte index and start-delay counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= 8'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    // Next state and bus fields; a fresh start overrides whatever cycle is in flight,
    // but the current cycle's strobe still goes out since outputs follow the present state.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        wdata   = 8'h00;
        case (state)
            ST_IDLE: begin
            end
            ST_DELAY: begin
                if (cnt == DELAY_LAST) begin
                    state_n = ST_RD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_RD: begin
                rd      = 1'b1;
                addr    = {page, idx};
                state_n = ST_WR;
            end
            ST_WR: begin
                wr    = 1'b1;
                addr  = DEST_BASE + {8'h00, idx};
                wdata = bus_rdata;
                if (idx == LAST_IDX) begin
                    state_n = ST_IDLE;
                    idx_n   = 8'd0;
                end else begin
                    state_n = ST_RD;
                    idx_n   = idx + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (start) begin
            state_n = START_STATE;
            idx_n   = 8'd0;
            cnt_n   = 8'd0;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - CPU/DMA bus arbiter with high-page port and DMA page register
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] DEST_BASE    = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter int          START_DELAY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] hi_addr,
    output logic [7:0]  hi_wdata,
    output logic        hi_rd,
    output logic        hi_wr,
    input  logic [7:0]  hi_rdata,
    output logic        dma_active
);

    logic [7:0]  page;
    rdata_sel_t  rsel;
    logic        is_reg, is_low, is_high, rd_req, start;
    logic        seq_rd, seq_wr;
    logic [15:0] seq_addr;
    logic [7:0]  seq_wdata;

    assign is_reg  = (cpu_addr == DMA_REG_ADDR);
    assign is_low  = !is_reg && (cpu_addr[15:8] != HIGH_PAGE);
    assign is_high = !is_reg && (cpu_addr[15:8] == HIGH_PAGE);
    // A simultaneous read and write is treated purely as a write.
    assign rd_req  = cpu_rd && !cpu_wr;
    assign start   = cpu_wr && is_reg;

    oam_dma_controller_dma_sequencer #(
        .DEST_BASE   (DEST_BASE),
        .DMA_LEN     (DMA_LEN),
        .START_DELAY (START_DELAY)
    ) u_seq (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .page      (page),
        .bus_rdata (bus_rdata),
        .active    (dma_active),
        .rd        (seq_rd),
        .wr        (seq_wr),
        .addr      (seq_addr),
        .wdata     (seq_wdata)
    );

    // Page register and the source select for next cycle's CPU read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            page <= PAGE_RESET;
            rsel <= SEL_CONST;
        end else begin
            if (start) begin
                page <= cpu_wdata;
            end
            if (rd_req) begin
                if (is_reg) begin
                    rsel <= SEL_REG;
                end else if (is_high) begin
                    rsel <= SEL_HI;
                end else if (dma_active) begin
                    rsel <= SEL_CONST;
                end else begin
                    rsel <= SEL_BUS;
                end
            end
        end
    end

    // Main bus owner: the DMA engine while active, otherwise low-page CPU traffic.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        if (dma_active) begin
            bus_addr  = seq_addr;
            bus_wdata = seq_wdata;
            bus_rd    = seq_rd;
            bus_wr    = seq_wr;
        end else if (is_low) begin
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
            bus_rd    = rd_req;
            bus_wr    = cpu_wr;
        end
    end

    // High-page port always follows the CPU so HRAM code keeps running during DMA.
    always_comb begin
        hi_addr  = 16'h0000;
        hi_wdata = 8'h00;
        hi_rd    = 1'b0;
        hi_wr    = 1'b0;
        if (is_high) begin
            hi_addr  = cpu_addr;
            hi_wdata = cpu_wdata;
            hi_rd    = rd_req;
            hi_wr    = cpu_wr;
        end
    end

    // CPU read data mux driven by the select captured on the previous read.
    always_comb begin
        cpu_rdata = RDATA_CONST;
        case (rsel)
            SEL_BUS:   cpu_rdata = bus_rdata;
            SEL_HI:    cpu_rdata = hi_rdata;
            SEL_REG:   cpu_rdata = page;
            SEL_CONST: cpu_rdata = RDATA_CONST;
            default:   cpu_rdata = RDATA_CONST;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

    localparam int START_DELAY = 1;
    localparam int DMA_LEN     = 160;
    localparam int LAST_POS    = START_DELAY + 2 * DMA_LEN - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd, bus_wr;
    logic [7:0]  bus_rdata = 8'h00;
    logic [15:0] hi_addr;
    logic [7:0]  hi_wdata;
    logic        hi_rd, hi_wr;
    logic [7:0]  hi_rdata = 8'h00;
    logic        dma_active;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  hmem [0:255];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    oam_dma_controller dut (
        .clock      (clk),
        .reset      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_rdata  (bus_rdata),
        .hi_addr    (hi_addr),
        .hi_wdata   (hi_wdata),
        .hi_rd      (hi_rd),
        .hi_wr      (hi_wr),
        .hi_rdata   (hi_rdata),
        .dma_active (dma_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memories behind the main bus and the high-page port.
    always @(posedge clk) begin
        if (bus_rd) bus_rdata = mem[bus_addr];
        if (bus_wr) mem[bus_addr] = bus_wdata;
        if (hi_rd)  hi_rdata = hmem[hi_addr[7:0]];
        if (hi_wr)  hmem[hi_addr[7:0]] = hi_wdata;
    end

    // Reference model: a DMA is "pos cycles into its run"; pos maps arithmetically to delay/read/write.
    bit          dma_on = 1'b0;
    bit          chk_rd = 1'b0;
    bit          is_hi;
    int          pos = 0;
    int          k = 0;
    logic [7:0]  mpage = 8'hFF;
    logic [7:0]  exp_rd = 8'hFF;
    logic        e_brd, e_bwr, e_hrd, e_hwr;
    logic [15:0] e_baddr;
    logic [7:0]  e_bwd;
    int          n_wr = 0, wcyc = 0, last_wr_cyc = 0;
    logic [15:0] last_wr_addr = 16'h0000, first_rd = 16'h0000;
    bit          got_rd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            dma_on = 1'b0;
            mpage  = 8'hFF;
            chk_rd = 1'b0;
            chk("reset_quiet", 32'({bus_rd, bus_wr, hi_rd, hi_wr, dma_active}), 0);
        end else begin
            e_brd = 1'b0; e_bwr = 1'b0; e_baddr = 16'h0000; e_bwd = 8'h00;
            if (dma_on) begin
                if (pos >= START_DELAY) begin
                    k = pos - START_DELAY;
                    if (k % 2 == 0) begin
                        e_brd   = 1'b1;
                        e_baddr = {mpage, 8'(k / 2)};
                    end else begin
                        e_bwr   = 1'b1;
                        e_baddr = 16'hFE00 + 16'(k / 2);
                        e_bwd   = mem[{mpage, 8'(k / 2)}];
                    end
                end
            end else if (cpu_addr[15:8] != 8'hFF) begin
                e_brd   = cpu_rd & ~cpu_wr;
                e_bwr   = cpu_wr;
                e_baddr = cpu_addr;
                e_bwd   = cpu_wdata;
            end
            is_hi = (cpu_addr[15:8] == 8'hFF) && (cpu_addr != 16'hFF46);
            e_hrd = is_hi & cpu_rd & ~cpu_wr;
            e_hwr = is_hi & cpu_wr;

            chk("dma_active", 32'(dma_active), 32'(dma_on));
            chk("bus_rd", 32'(bus_rd), 32'(e_brd));
            chk("bus_wr", 32'(bus_wr), 32'(e_bwr));
            chk("hi_rd", 32'(hi_rd), 32'(e_hrd));
            chk("hi_wr", 32'(hi_wr), 32'(e_hwr));
            if (e_brd || e_bwr) chk("bus_addr", 32'(bus_addr), 32'(e_baddr));
            if (e_bwr) chk("bus_wdata", 32'(bus_wdata), 32'(e_bwd));
            if (e_hrd || e_hwr) chk("hi_addr", 32'(hi_addr), 32'(cpu_addr));
            if (e_hwr) chk("hi_wdata", 32'(hi_wdata), 32'(cpu_wdata));
            if (chk_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));

            if (bus_wr) begin
                n_wr++;
                last_wr_addr = bus_addr;
                last_wr_cyc  = cyc;
            end
            if (bus_rd && !got_rd) begin
                got_rd   = 1'b1;
                first_rd = bus_addr;
            end

            chk_rd = cpu_rd & ~cpu_wr;
            if (chk_rd) begin
                if (cpu_addr == 16'hFF46) exp_rd = mpage;
                else if (is_hi)           exp_rd = hmem[cpu_addr[7:0]];
                else if (dma_on)          exp_rd = 8'hFF;
                else                      exp_rd = mem[cpu_addr];
            end
            if (dma_on) begin
                if (pos == LAST_POS) dma_on = 1'b0;
                else pos++;
            end
            if (cpu_wr && cpu_addr == 16'hFF46) begin
                dma_on = 1'b1;
                pos    = 0;
                mpage  = cpu_wdata;
                n_wr   = 0;
                got_rd = 1'b0;
                wcyc   = cyc;
            end
        end
    end

    task automatic op(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_rd = r; cpu_wr = w; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (dma_active && n < 1000) begin
            idle();
            n++;
        end
        chk("dma_done_in_time", 32'(dma_active), 0);
    endtask

    task automatic wait_for_rd(input logic [15:0] target);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 400) begin
            idle();
            hit = bus_rd && (bus_addr == target);
            n++;
        end
        chk("found_rd", 32'(hit), 1);
    endtask

    task automatic check_oam(input string name, input logic [15:0] src);
        int errs;
        errs = 0;
        for (int i = 0; i < DMA_LEN; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== mem[src + 16'(i)]) errs++;
        end
        chk(name, 32'(errs), 0);
    endtask

    int          r;
    logic [15:0] la, ha;
    logic [7:0]  d;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) hmem[i] = 8'($urandom);
        mem[16'hC000] = 8'h5A;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdata", 32'(cpu_rdata), 32'h0000_00FF);
        chk("reset_active", 32'(dma_active), 0);

        // CPU owns the bus while idle
        op(1'b1, 1'b0, 16'hC000, 8'h00);
        chk("t1_bus_rd", 32'(bus_rd), 1);
        chk("t1_bus_addr", 32'(bus_addr), 32'h0000_C000);
        idle();
        chk("t1_rdata", 32'(cpu_rdata), 32'h0000_005A);

        // full transfer from page C1 with CPU traffic in the middle
        op(1'b0, 1'b1, 16'hFF46, 8'hC1);
        idle();
        chk("t2_active", 32'(dma_active), 1);
        repeat (5) idle();
        op(1'b1, 1'b0, 16'h8000, 8'h00);
        idle();
        chk("t3_rdata_ff", 32'(cpu_rdata), 32'h0000_00FF);
        op(1'b0, 1'b1, 16'hC000, 8'h11);
        op(1'b0, 1'b1, 16'hFF80, 8'h33);
        chk("t3_hi_wr", 32'(hi_wr), 1);
        chk("t3_hi_addr", 32'(hi_addr), 32'h0000_FF80);
        wait_idle();
        chk("t2_last_addr", 32'(last_wr_addr), 32'h0000_FE9F);
        chk("t2_last_cycle", 32'(last_wr_cyc - wcyc), 321);
        chk("t2_count", 32'(n_wr), 160);
        check_oam("t2_oam", 16'hC100);
        chk("t3_dropped", 32'(mem[16'hC000]), 32'h0000_005A);

        // register read-back
        op(1'b1, 1'b0, 16'hFF46, 8'h00);
        chk("t4_hi_rd", 32'(hi_rd), 0);
        idle();
        chk("t4_rdata", 32'(cpu_rdata), 32'h0000_00C1);

        // restart on the write cycle of idx 50
        op(1'b0, 1'b1, 16'hFF46, 8'hC2);
        wait_for_rd(16'hC232);
        op(1'b0, 1'b1, 16'hFF46, 8'hD0);
        chk("t5_wr_inflight", 32'(bus_wr), 1);
        chk("t5_wr_addr", 32'(bus_addr), 32'h0000_FE32);
        wait_idle();
        chk("t5_first_rd", 32'(first_rd), 32'h0000_D000);
        chk("t5_count", 32'(n_wr), 160);
        chk("t5_last_addr", 32'(last_wr_addr), 32'h0000_FE9F);
        check_oam("t5_oam", 16'hD000);

        // reset in the middle of a transfer
        op(1'b0, 1'b1, 16'hFF46, 8'hC3);
        wait_for_rd(16'hC30A);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_strobes", 32'({bus_rd, bus_wr, hi_rd, hi_wr}), 0);
        chk("t6_active", 32'(dma_active), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle();
        chk("t6_rdata", 32'(cpu_rdata), 32'h0000_00FF);
        op(1'b1, 1'b0, 16'hC000, 8'h00);
        chk("t6_bus_rd", 32'(bus_rd), 1);
        idle();
        chk("t6_read", 32'(cpu_rdata), 32'h0000_005A);

        // random traffic with occasional DMA starts and restarts
        for (int i = 0; i < 4000; i++) begin
            r  = $urandom_range(0, 999);
            la = 16'($urandom_range(0, 16'hFEFF));
            ha = {8'hFF, 8'($urandom)};
            if (ha == 16'hFF46) ha = 16'hFF47;
            d  = 8'($urandom);
            if (r < 300)      idle();
            else if (r < 450) op(1'b1, 1'b0, la, d);
            else if (r < 550) op(1'b0, 1'b1, la, d);
            else if (r < 680) op(1'b1, 1'b0, ha, d);
            else if (r < 800) op(1'b0, 1'b1, ha, d);
            else if (r < 880) op(1'b1, 1'b0, 16'hFF46, d);
            else if (r < 930) op(1'b1, 1'b1, la, d);
            else if (r < 960) op(1'b1, 1'b1, ha, d);
            else if (r < 995) idle();
            else              op(1'b0, 1'b1, 16'hFF46, 8'($urandom_range(0, 254)));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
